img_loader: RTL and testbench
=============================

IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 SHALL have parameter HEIGHT, default 480, frame height in pixels.
REQ-002 SHALL have parameter WIDTH, default 800, frame width in pixels; HEIGHT*WIDTH SHALL NOT exceed 2^19.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes on rising i_clk.
REQ-004 i_clk  input  1  system clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_start  input  1  one-cycle pulse; begins loading one frame.
REQ-007 i_valid  input  1  i_pixel holds a valid pixel.
REQ-008 i_pixel  input  24  pixel {R[23:16], G[15:8], B[7:0]}, raster order.
REQ-009 o_ready  output  1  loader accepts a pixel this cycle.
REQ-010 o_sram_req  output  1  loader requests the SRAM port.
REQ-011 i_sram_grant  input  1  SRAM port granted this cycle.
REQ-012 o_sram_we  output  1  write strobe, active high.
REQ-013 o_sram_addr  output  20  word address {pixel_index[18:0], half}.
REQ-014 o_sram_wdata  output  16  write data.
REQ-015 o_busy  output  1  frame load in progress.
REQ-016 o_done  output  1  one-cycle pulse when the last pixel's second word is written.

Function
REQ-017 SHALL implement states IDLE, WAIT_PIX, WR_LO, WR_HI, DONE.
REQ-018 IDLE: i_start=1 -> WAIT_PIX, pixel index cleared to 0; other inputs ignored.
REQ-019 WAIT_PIX: o_ready=1; i_valid=1 -> latch i_pixel, go WR_LO; i_valid=0 -> stay.
REQ-020 o_ready SHALL be 1 only in WAIT_PIX; pixels offered in any other state SHALL NOT be consumed.
REQ-021 WR_LO: o_sram_req=1, o_sram_addr={index,1'b0}, o_sram_wdata={8'h00,R}; o_sram_we=i_sram_grant; grant=1 -> WR_HI, else stay.
REQ-022 WR_HI: o_sram_req=1, o_sram_addr={index,1'b1}, o_sram_wdata={G,B}; o_sram_we=i_sram_grant; stay until grant.
REQ-023 WR_HI with grant: index==HEIGHT*WIDTH-1 -> DONE; otherwise index+1, go WAIT_PIX.
REQ-024 DONE: o_done=1 for exactly that cycle; next state IDLE.
REQ-025 o_busy SHALL be 1 in WAIT_PIX, WR_LO, WR_HI, DONE; 0 in IDLE.
REQ-026 Outside WR_LO/WR_HI: o_sram_req=0, o_sram_we=0, o_sram_wdata=0, o_sram_addr={index,1'b0}.
REQ-027 o_sram_we SHALL never be 1 while i_sram_grant=0; a deasserted grant SHALL stall the FSM with address and data held stable.
REQ-028 i_start while o_busy=1 SHALL be ignored (no restart, no index change).
REQ-029 Minimum throughput: 3 cycles per pixel (WAIT_PIX, WR_LO, WR_HI) with grant and valid held high.
REQ-030 Pixel index SHALL be 19 bits, unsigned, counting 0..HEIGHT*WIDTH-1 without wrap inside a frame.

Reset
REQ-031 i_rst=1 at a rising edge SHALL force IDLE, index 0, latched pixel 0, regardless of current state.
REQ-032 After reset all outputs SHALL be 0 (o_ready, o_sram_req, o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_done).
REQ-033 Reset mid-frame SHALL abandon the frame; no o_done; a fresh i_start restarts at index 0.

Verification
REQ-034 Basic write: i_start, grant=1, pixel 24'hA1B2C3 -> we at addr 20'h00000 data 16'h00A1, next cycle addr 20'h00001 data 16'hB2C3.
REQ-035 Grant stall: grant=0 for 5 cycles in WR_LO -> o_sram_req=1, o_sram_we=0, addr/data stable; write occurs on first grant cycle.
REQ-036 Full frame (HEIGHT=2, WIDTH=3): 6 pixels streamed -> 12 writes, addrs 0..11 in order, o_done one cycle after last write, then IDLE.
REQ-037 Backpressure: i_valid held high continuously -> o_ready high 1 of every 3 cycles; each pixel written exactly once.
REQ-038 i_start while busy at index 2 -> ignored, load continues from index 2.
REQ-039 Reset in WR_HI at index 4 -> all outputs 0 next cycle; new i_start writes first word to addr 20'h00000.

Source files
------------

// File: rtl/img_loader_if.sv
// Pixel-stream and SRAM-write signals exchanged between a frame source and the loader.
interface img_loader_if;
  logic        i_start;
  logic        i_valid;
  logic [23:0] i_pixel;
  logic        o_ready;
  logic        o_sram_req;
  logic        i_sram_grant;
  logic        o_sram_we;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_start, i_valid, i_pixel, i_sram_grant,
    input  o_ready, o_sram_req, o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_done
  );

  modport slave (
    input  i_start, i_valid, i_pixel, i_sram_grant,
    output o_ready, o_sram_req, o_sram_we, o_sram_addr, o_sram_wdata, o_busy, o_done
  );
endinterface

// File: rtl/img_loader.sv
// Loads one raster frame of 24-bit pixels into a 16-bit SRAM, two words per pixel, 3 cycles/pixel best case.
// Stalls in WAIT_PIX until i_valid and in WR_LO/WR_HI until i_sram_grant, holding address and data stable.
module img_loader #(
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned WIDTH  = 800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  img_loader_if.slave bus
);

  localparam int unsigned FRAME_PIX = HEIGHT * WIDTH;
  localparam logic [18:0] LAST_IDX  = 19'(FRAME_PIX - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_PIX = 3'd1;
  localparam logic [2:0] S_WR_LO    = 3'd2;
  localparam logic [2:0] S_WR_HI    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [18:0] index_q, index_d;
  logic [23:0] pixel_q, pixel_d;

  logic        ready;
  logic        sram_req;
  logic        sram_we;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        busy;
  logic        done;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    pixel_d = pixel_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_WAIT_PIX;
          index_d = '0;
        end
      end
      S_WAIT_PIX: begin
        if (bus.i_valid) begin
          pixel_d = bus.i_pixel;
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (bus.i_sram_grant) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        if (bus.i_sram_grant) begin
          // The index never advances past the last pixel, so it cannot wrap inside a frame.
          if (index_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 19'd1;
            state_d = S_WAIT_PIX;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = {index_q, 1'b0};
    sram_wdata = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE:     busy = 1'b0;
      S_WAIT_PIX: ready = 1'b1;
      S_WR_LO: begin
        sram_req   = 1'b1;
        sram_we    = bus.i_sram_grant;
        sram_wdata = {8'h00, pixel_q[23:16]};
      end
      S_WR_HI: begin
        sram_req   = 1'b1;
        sram_we    = bus.i_sram_grant;
        sram_addr  = {index_q, 1'b1};
        sram_wdata = pixel_q[15:0];
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      pixel_q <= pixel_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_sram_req   = sram_req;
  assign bus.o_sram_we    = sram_we;
  assign bus.o_sram_addr  = sram_addr;
  assign bus.o_sram_wdata = sram_wdata;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;

endmodule

// File: tb/tb_img_loader.sv
// Scoreboard bench for img_loader on a 2x3 frame: expected SRAM writes are queued per frame, a negedge monitor pops them.
module tb_img_loader;

  localparam int H    = 2;
  localparam int W    = 3;
  localparam int NPIX = H * W;
  localparam logic [19:0] LAST_ADDR = 20'(2 * NPIX - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  img_loader_if bus ();

  img_loader #(.HEIGHT(H), .WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks     = 0;
  int  failures   = 0;
  bit  grant_rand = 1'b0;
  bit  prev_last  = 1'b0;
  wr_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.o_ready), 0);
    check({tag, "_req"},   32'(bus.o_sram_req), 0);
    check({tag, "_we"},    32'(bus.o_sram_we), 0);
    check({tag, "_addr"},  32'(bus.o_sram_addr), 0);
    check({tag, "_wdata"}, 32'(bus.o_sram_wdata), 0);
    check({tag, "_busy"},  32'(bus.o_busy), 0);
    check({tag, "_done"},  32'(bus.o_done), 0);
  endtask

  // Advance one clock; reports whether a pixel handshake happened on that edge.
  task automatic tick(output bit acc);
    acc = bus.o_ready && bus.i_valid;
    @(posedge clk);
    #1;
    if (grant_rand) bus.i_sram_grant = 1'($urandom_range(0, 1));
  endtask

  // Monitor: every SRAM write must match the next expected word; o_done must follow the final word.
  always @(negedge clk) begin
    if (rst) begin
      prev_last = 1'b0;
    end else begin
      if (bus.o_done || prev_last) check("done_after_last_write", 32'(bus.o_done), 32'(prev_last));
      prev_last = 1'b0;
      if (bus.o_sram_we) begin
        check("we_only_with_grant", 32'(bus.i_sram_grant), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 32'(bus.o_sram_addr), 32'hFFFFFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", 32'(bus.o_sram_addr), 32'(mon_e.addr));
          check("write_data", 32'(bus.o_sram_wdata), 32'(mon_e.data));
          prev_last = (mon_e.addr == LAST_ADDR);
        end
      end
    end
  end

  task automatic send_frame(input bit gaps, input bit grnd, input bit stall,
                            input int start_at, input int abort_at, input bit fixed_first);
    logic [23:0] pix[NPIX];
    bit acc;
    int n;
    for (int k = 0; k < NPIX; k++) pix[k] = 24'($urandom);
    if (fixed_first) pix[0] = 24'hA1B2C3;
    for (int k = 0; k < NPIX; k++) begin
      exp_q.push_back('{addr: 20'(2 * k),     data: {8'h00, pix[k][23:16]}});
      exp_q.push_back('{addr: 20'(2 * k + 1), data: pix[k][15:0]});
    end
    grant_rand       = grnd;
    bus.i_sram_grant = stall ? 1'b0 : 1'b1;
    bus.i_start      = 1'b1;
    tick(acc);
    bus.i_start = 1'b0;
    check("busy_after_start", 32'(bus.o_busy), 1);
    for (int k = 0; k < NPIX; k++) begin
      bus.i_pixel = pix[k];
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
        bus.i_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.i_start = (k == start_at);
        tick(acc);
        n++;
      end
      bus.i_start = 1'b0;
      if (!acc) begin
        check("pixel_accept_timeout", 32'(n), 0);
        bus.i_valid = 1'b0;
        exp_q.delete();
        return;
      end
      if (!gaps && !grnd && !stall) check("cycles_per_pixel", 32'(n), (k == 0) ? 1 : 3);
      if (fixed_first && k == 0 && !stall && !grnd) begin
        check("first_word_addr", 32'(bus.o_sram_addr), 0);
        check("first_word_data", 32'(bus.o_sram_wdata), 32'h00A1);
      end
      if (stall && k == 0) begin
        bus.i_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
          check("stall_req", 32'(bus.o_sram_req), 1);
          check("stall_we", 32'(bus.o_sram_we), 0);
          check("stall_addr", 32'(bus.o_sram_addr), 0);
          check("stall_data", 32'(bus.o_sram_wdata), {24'h0, pix[0][23:16]});
          tick(acc);
        end
        bus.i_sram_grant = 1'b1;
        #1;
        check("stall_release_we", 32'(bus.o_sram_we), 1);
      end
      if (k == abort_at) begin
        bus.i_valid = 1'b0;
        tick(acc);
        bus.i_sram_grant = 1'b0;
        #1;
        check("abort_in_wr_hi_addr", 32'(bus.o_sram_addr), 32'(2 * k + 1));
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        check_all_zero("abort");
        exp_q.delete();
        bus.i_sram_grant = 1'b1;
        return;
      end
    end
    bus.i_valid = 1'b0;
    n = 0;
    while (bus.o_busy && n < 100) begin
      tick(acc);
      n++;
    end
    check("idle_after_frame", 32'(bus.o_busy), 0);
    check("ready_low_in_idle", 32'(bus.o_ready), 0);
    check("all_writes_seen", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    bus.i_start      = 1'b0;
    bus.i_valid      = 1'b0;
    bus.i_pixel      = '0;
    bus.i_sram_grant = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    send_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b1);
    send_frame(1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0,  2, -1, 1'b0);
    send_frame(1'b1, 1'b1, 1'b0,  2, -1, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0, -1,  4, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0, -1, -1, 1'b1);
    for (int r = 0; r < 4; r++) send_frame(1'b1, 1'b1, 1'b0, -1, -1, 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
